// File: rtl/gradients_2.sv
// Directional-gradient engine for CFA demosaicing: 5x5 window in, short/full
// H/V gradients and complementary direction weights out, 3-stage pipeline.

module gradients_2_absdiff #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);
    assign d = (a > b) ? (a - b) : (b - a);
endmodule

module gradients_2 #(
    parameter int PIX_W = 12,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
    input  logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
    input  logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
    input  logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
    input  logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
    output logic [OUT_W-1:0] grad_hs,
    output logic [OUT_W-1:0] grad_vs,
    output logic [OUT_W-1:0] grad_hf,
    output logic [OUT_W-1:0] grad_vf,
    output logic [OUT_W-1:0] w_grad_hf,
    output logic [OUT_W-1:0] w_grad_vf
);
    localparam int NH    = 20;           // adjacent-pair differences per direction
    localparam int D2_W  = PIX_W + 3;    // signed second-difference width
    localparam int SUM_W = PIX_W + 5;    // 20 * (2^PIX_W - 1) fits
    localparam int NUM_W = OUT_W + 8;    // 256 * grad
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    typedef logic [4:0][4:0][PIX_W-1:0] win_t;

    typedef struct packed {
        logic [NH-1:0][PIX_W-1:0] hd;
        logic [NH-1:0][PIX_W-1:0] vd;
        logic [PIX_W-1:0]         hs1;
        logic [PIX_W-1:0]         vs1;
        logic [D2_W-1:0]          hs2;
        logic [D2_W-1:0]          vs2;
    } s1_t;

    typedef struct packed {
        logic [OUT_W-1:0] hs;
        logic [OUT_W-1:0] vs;
        logic [OUT_W-1:0] hf;
        logic [OUT_W-1:0] vf;
    } s2_t;

    function automatic logic [OUT_W-1:0] sat_sum(input logic [SUM_W-1:0] x);
        return (x > SUM_W'(OUT_MAX)) ? OUT_MAX : x[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] sat_q(input logic [NUM_W-1:0] x);
        return (x > NUM_W'(OUT_MAX)) ? OUT_MAX : x[OUT_W-1:0];
    endfunction

    function automatic logic [D2_W-1:0] abs_d2(input logic [PIX_W-1:0] c,
                                                input logic [PIX_W-1:0] l,
                                                input logic [PIX_W-1:0] r);
        logic signed [D2_W-1:0] s;
        s = $signed({2'b00, c, 1'b0}) - $signed({3'b000, l}) - $signed({3'b000, r});
        return s[D2_W-1] ? unsigned'(-s) : unsigned'(s);
    endfunction

    // window as [row][col], index 0..4 maps to -2..+2
    win_t pix, pix_q;
    assign pix[0][0] = p_m2_m2; assign pix[0][1] = p_m2_m1; assign pix[0][2] = p_m2_p0;
    assign pix[0][3] = p_m2_p1; assign pix[0][4] = p_m2_p2;
    assign pix[1][0] = p_m1_m2; assign pix[1][1] = p_m1_m1; assign pix[1][2] = p_m1_p0;
    assign pix[1][3] = p_m1_p1; assign pix[1][4] = p_m1_p2;
    assign pix[2][0] = p_p0_m2; assign pix[2][1] = p_p0_m1; assign pix[2][2] = p_p0_p0;
    assign pix[2][3] = p_p0_p1; assign pix[2][4] = p_p0_p2;
    assign pix[3][0] = p_p1_m2; assign pix[3][1] = p_p1_m1; assign pix[3][2] = p_p1_p0;
    assign pix[3][3] = p_p1_p1; assign pix[3][4] = p_p1_p2;
    assign pix[4][0] = p_p2_m2; assign pix[4][1] = p_p2_m1; assign pix[4][2] = p_p2_p0;
    assign pix[4][3] = p_p2_p1; assign pix[4][4] = p_p2_p2;

    logic [2:0] vld_pipe;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;

    // Edge 0: window capture and valid tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], start};
            if (start) pix_q <= pix;
        end
    end

    // Stage 1: absolute differences, one lane per adjacent pair
    genvar gr, gc;
    generate
        for (gr = 0; gr < 5; gr++) begin : g_row
            for (gc = 0; gc < 4; gc++) begin : g_col
                gradients_2_absdiff #(.W(PIX_W)) u_hd (
                    .a(pix_q[gr][gc]), .b(pix_q[gr][gc+1]), .d(s1_d.hd[gr*4+gc])
                );
                gradients_2_absdiff #(.W(PIX_W)) u_vd (
                    .a(pix_q[gc][gr]), .b(pix_q[gc+1][gr]), .d(s1_d.vd[gr*4+gc])
                );
            end
        end
    endgenerate

    gradients_2_absdiff #(.W(PIX_W)) u_hs1 (.a(pix_q[2][1]), .b(pix_q[2][3]), .d(s1_d.hs1));
    gradients_2_absdiff #(.W(PIX_W)) u_vs1 (.a(pix_q[1][2]), .b(pix_q[3][2]), .d(s1_d.vs1));
    assign s1_d.hs2 = abs_d2(pix_q[2][2], pix_q[2][0], pix_q[2][4]);
    assign s1_d.vs2 = abs_d2(pix_q[2][2], pix_q[0][2], pix_q[4][2]);

    // Stage 2: sums, shift, saturate
    logic [SUM_W-1:0] hf_sum, vf_sum, hs_sum, vs_sum;
    always_comb begin
        hf_sum = '0;
        vf_sum = '0;
        for (int i = 0; i < NH; i++) begin
            hf_sum = hf_sum + SUM_W'(s1_q.hd[i]);
            vf_sum = vf_sum + SUM_W'(s1_q.vd[i]);
        end
        hs_sum = SUM_W'(s1_q.hs1) + SUM_W'(s1_q.hs2);
        vs_sum = SUM_W'(s1_q.vs1) + SUM_W'(s1_q.vs2);
    end

    assign s2_d.hs = sat_sum(hs_sum >> 4);
    assign s2_d.vs = sat_sum(vs_sum >> 4);
    assign s2_d.hf = sat_sum(hf_sum >> 6);
    assign s2_d.vf = sat_sum(vf_sum >> 6);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Stage 3: weights from the saturated full gradients; denominator is never 0
    logic [OUT_W:0]     den;
    logic [NUM_W-1:0]   q_h, q_v;
    assign den = {1'b0, s2_q.hf} + {1'b0, s2_q.vf} + {{OUT_W{1'b0}}, 1'b1};
    assign q_h = {s2_q.vf, 8'h00} / NUM_W'(den);
    assign q_v = {s2_q.hf, 8'h00} / NUM_W'(den);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grad_hs   <= '0;
            grad_vs   <= '0;
            grad_hf   <= '0;
            grad_vf   <= '0;
            w_grad_hf <= '0;
            w_grad_vf <= '0;
        end else if (vld_pipe[2]) begin
            grad_hs   <= s2_q.hs;
            grad_vs   <= s2_q.vs;
            grad_hf   <= s2_q.hf;
            grad_vf   <= s2_q.vf;
            w_grad_hf <= sat_q(q_h);
            w_grad_vf <= sat_q(q_v);
        end
    end
endmodule

// File: tb/tb_gradients_2.sv
// Self-checking bench for gradients_2: directed test-plan patches plus random
// windows, scored against an arithmetic reference and a latency-3 scoreboard.

module tb_gradients_2;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] win [5][5];
    logic [7:0]  grad_hs, grad_vs, grad_hf, grad_vf, w_grad_hf, w_grad_vf;

    typedef struct packed {
        logic [7:0] hs, vs, hf, vf, whf, wvf;
    } res_t;

    res_t hist_e[$];
    bit   hist_v[$];
    res_t exp_o;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gradients_2 #(.PIX_W(12), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p_m2_m2(win[0][0]), .p_m2_m1(win[0][1]), .p_m2_p0(win[0][2]), .p_m2_p1(win[0][3]), .p_m2_p2(win[0][4]),
        .p_m1_m2(win[1][0]), .p_m1_m1(win[1][1]), .p_m1_p0(win[1][2]), .p_m1_p1(win[1][3]), .p_m1_p2(win[1][4]),
        .p_p0_m2(win[2][0]), .p_p0_m1(win[2][1]), .p_p0_p0(win[2][2]), .p_p0_p1(win[2][3]), .p_p0_p2(win[2][4]),
        .p_p1_m2(win[3][0]), .p_p1_m1(win[3][1]), .p_p1_p0(win[3][2]), .p_p1_p1(win[3][3]), .p_p1_p2(win[3][4]),
        .p_p2_m2(win[4][0]), .p_p2_m1(win[4][1]), .p_p2_p0(win[4][2]), .p_p2_p1(win[4][3]), .p_p2_p2(win[4][4]),
        .grad_hs(grad_hs), .grad_vs(grad_vs), .grad_hf(grad_hf), .grad_vf(grad_vf),
        .w_grad_hf(w_grad_hf), .w_grad_vf(w_grad_vf)
    );

    function automatic int px(int r, int c);
        return int'(win[r+2][c+2]);
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int sat(int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic res_t ref_model();
        int hs, vs, hf, vf, d;
        res_t r;
        hs = sat((iabs(px(0,-1) - px(0,1)) + iabs(2*px(0,0) - px(0,-2) - px(0,2))) / 16);
        vs = sat((iabs(px(-1,0) - px(1,0)) + iabs(2*px(0,0) - px(-2,0) - px(2,0))) / 16);
        hf = 0;
        vf = 0;
        for (int a = -2; a <= 2; a++)
            for (int b = -2; b <= 1; b++) begin
                hf += iabs(px(a,b) - px(a,b+1));
                vf += iabs(px(b,a) - px(b+1,a));
            end
        hf = sat(hf / 64);
        vf = sat(vf / 64);
        d  = hf + vf + 1;
        r.hs  = 8'(hs);
        r.vs  = 8'(vs);
        r.hf  = 8'(hf);
        r.vf  = 8'(vf);
        r.whf = 8'(sat((256 * vf) / d));
        r.wvf = 8'(sat((256 * hf) / d));
        return r;
    endfunction

    task automatic set_pat(input int kind);
        int base;
        base = int'($urandom_range(0, 3800));
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                case (kind)
                    0: win[r][c] = 12'd1000;
                    1: win[r][c] = 12'(100 * c);
                    2: win[r][c] = (c % 2 == 0) ? 12'd4095 : 12'd0;
                    3: win[r][c] = (r == 2 && c == 2) ? 12'd4095 : 12'd0;
                    4: win[r][c] = 12'($urandom_range(0, 4095));
                    default: win[r][c] = 12'(base + int'($urandom_range(0, 295)));
                endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check6(input string tag, input res_t e);
        chk({tag, ".grad_hs"},   grad_hs,   e.hs);
        chk({tag, ".grad_vs"},   grad_vs,   e.vs);
        chk({tag, ".grad_hf"},   grad_hf,   e.hf);
        chk({tag, ".grad_vf"},   grad_vf,   e.vf);
        chk({tag, ".w_grad_hf"}, w_grad_hf, e.whf);
        chk({tag, ".w_grad_vf"}, w_grad_vf, e.wvf);
    endtask

    // One clock: drive start, record the slot, advance the output model, check at negedge
    task automatic cycle(input string tag, input logic s);
        int k;
        start = s;
        @(posedge clk);
        hist_v.push_back(s);
        hist_e.push_back(s ? ref_model() : res_t'(0));
        k = hist_v.size() - 1;
        if (k >= 3 && hist_v[k-3]) exp_o = hist_e[k-3];
        @(negedge clk);
        check6(tag, exp_o);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        exp_o = '0;
        set_pat(0);
        #12;
        check6("reset", exp_o);
        @(negedge clk);
        rst = 1'b1;

        // Individual test-plan patches
        for (int p = 0; p < 4; p++) begin
            set_pat(p);
            cycle($sformatf("patch%0d", p), 1'b1);
            for (int i = 0; i < 3; i++) cycle($sformatf("patch%0d", p), 1'b0);
            if (p == 1) check6("ramp_const", '{8'd12, 8'd0, 8'd31, 8'd0, 8'd0, 8'd248});
            if (p == 3) check6("impulse_const", '{8'd255, 8'd255, 8'd127, 8'd127, 8'd127, 8'd127});
        end

        // Back-to-back stream then a start=0 gap
        for (int p = 0; p < 4; p++) begin
            set_pat(p);
            cycle("stream", 1'b1);
        end
        for (int i = 0; i < 5; i++) cycle("stream_gap", 1'b0);
        check6("gap_hold", '{8'd255, 8'd255, 8'd127, 8'd127, 8'd127, 8'd127});

        // Random windows with random start gaps
        for (int i = 0; i < 60; i++) begin
            set_pat(int'($urandom_range(4, 5)));
            cycle("rand", logic'($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream, asserted between edges
        set_pat(4);
        cycle("pre_rst", 1'b1);
        set_pat(1);
        cycle("pre_rst", 1'b1);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        exp_o = '0;
        hist_v.delete();
        hist_e.delete();
        check6("rst_async", exp_o);
        @(posedge clk);
        @(negedge clk);
        check6("rst_hold", exp_o);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle("post_rst_idle", 1'b0);
        set_pat(1);
        cycle("post_rst", 1'b1);
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0);
        check6("post_rst_const", '{8'd12, 8'd0, 8'd31, 8'd0, 8'd0, 8'd248});

        for (int i = 0; i < 40; i++) begin
            set_pat(int'($urandom_range(2, 5)));
            cycle("rand2", logic'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gradients_2.md
Name: gradients_2

Overview:
- Directional-gradient engine for the CFA demosaicing datapath.
- Takes a 5x5 window of 12-bit raw pixels centred on the current pixel.
- Produces short-range and full-window horizontal/vertical gradients, plus a pair of complementary direction weights.
- Feeds the interpolation stage downstream. Fully pipelined: one window per clock.

Parameters:
- PIX_W, 12, input pixel width.
- OUT_W, 8, width of every output (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  input-valid qualifier; window is sampled on a rising clk edge when start=1.
- p_m2_m2 .. p_p2_p2  in  12 each  25 window pixels. Naming is p_<row>_<col>, row/col in {m2,m1,p0,p1,p2} = -2..+2. p_p0_p0 is the centre pixel.
- grad_hs  out  8  short horizontal gradient.
- grad_vs  out  8  short vertical gradient.
- grad_hf  out  8  full-window horizontal gradient.
- grad_vf  out  8  full-window vertical gradient.
- w_grad_hf  out  8  horizontal interpolation weight.
- w_grad_vf  out  8  vertical interpolation weight.

Behaviour:
- Reset: rst=0 asynchronously clears all pipeline registers, valid bits and all six outputs to 0. This holds while rst=0, and a reset asserted mid-stream discards in-flight windows. After release, no output changes until a new start is pipelined through.
- Notation: P(r,c) is the pixel at row r, column c. All arithmetic is unsigned and full-width; nothing wraps internally.
- grad_hs = sat255((|P(0,-1)-P(0,1)| + |2*P(0,0)-P(0,-2)-P(0,2)|) >> 4). The second-difference term uses a signed intermediate of at least 15 bits before abs.
- grad_vs: same formula along column 0, i.e. P(-1,0), P(1,0), P(0,0), P(-2,0), P(2,0).
- grad_hf = sat255((sum over r=-2..2, c=-2..1 of |P(r,c)-P(r,c+1)|) >> 6). This is 20 terms; the sum needs at least 17 bits.
- grad_vf = sat255((sum over c=-2..2, r=-2..1 of |P(r,c)-P(r+1,c)|) >> 6).
- sat255(x) = 255 if x>255, else x.
- Weights use the 8-bit saturated grad_hf and grad_vf. Let D = grad_hf + grad_vf + 1 (9 bits, never 0).
  - w_grad_hf = sat255(floor(256*grad_vf / D)).
  - w_grad_vf = sat255(floor(256*grad_hf / D)).
- Pipeline, 3 stages, latency 3 clocks:
  - Edge 0 (start=1): capture the window.
  - Stage 1: absolute differences.
  - Stage 2: sums, shift, saturate.
  - Stage 3: divide and register outputs.
- A 3-bit valid shift register tracks start. All six outputs update together, on the edge 3 cycles after the capturing edge, only when that valid bit is 1. Otherwise they hold their previous value.
- Throughput: start may be high every cycle; back-to-back windows emerge on consecutive cycles in order.
- A start=0 gap produces no update for that slot. Outputs hold, with no glitch to 0.
- Division is combinational within stage 3 (16-bit by 9-bit unsigned) or any equivalent that meets latency 3. No multicycle paths.

Test Plan:
- Flat patch, all pixels 1000, start=1 -> after 3 clocks all six outputs = 0.
- Horizontal ramp P(r,c) = 100*(c+2) -> grad_hs=12, grad_vs=0, grad_hf=31, grad_vf=0, w_grad_hf=0, w_grad_vf=248.
- Column stripes: P=4095 for c even, 0 for c odd -> grad_hs=0, grad_hf=255 (saturated), grad_vs=0, grad_vf=0, w_grad_hf=0, w_grad_vf=255.
- Centre impulse: P(0,0)=4095, others 0 -> grad_hs=255, grad_vs=255, grad_hf=127, grad_vf=127, w_grad_hf=127, w_grad_vf=127.
- Streaming: the four patches above on consecutive cycles with start=1 -> results on 4 consecutive cycles starting at latency 3, same order. Then start=0 for 5 cycles -> outputs hold the last (impulse) values.
- Reset mid-stream: drive rst=0 asynchronously between edges while windows are in flight -> outputs go to 0 immediately. After release, with start=0, outputs stay 0. The next start yields correct values 3 clocks later.
